// File: rtl/id_ex_stage_pkg.sv
// Shared decode/execute definitions: opcode constants, bubble instruction,
// register-address width and ID/EX skid-buffer state encoding.
package id_ex_stage_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [31:0] NOP_INST_DEF = 32'h00000013;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } stage_state_e;

endpackage

// File: rtl/id_ex_stage_entry.sv
// One ID/EX pipeline entry: instruction, PC, operands and destination,
// captured on load_i and held otherwise.
module id_ex_entry
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_i,
  input  logic [31:0]             inst_i,
  input  logic [DATA_WIDTH-1:0]   pc_i,
  input  logic [DATA_WIDTH-1:0]   op1_i,
  input  logic [DATA_WIDTH-1:0]   op2_i,
  input  logic [REG_ADDR_W-1:0]   waddr_i,
  input  logic                    we_i,
  output logic [31:0]             inst_o,
  output logic [DATA_WIDTH-1:0]   pc_o,
  output logic [DATA_WIDTH-1:0]   op1_o,
  output logic [DATA_WIDTH-1:0]   op2_o,
  output logic [REG_ADDR_W-1:0]   waddr_o,
  output logic                    we_o
);

  // entry payload register with load enable
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inst_o  <= NOP_INST_DEF;
      pc_o    <= {DATA_WIDTH{1'b0}};
      op1_o   <= {DATA_WIDTH{1'b0}};
      op2_o   <= {DATA_WIDTH{1'b0}};
      waddr_o <= {REG_ADDR_W{1'b0}};
      we_o    <= 1'b0;
    end else if (load_i) begin
      inst_o  <= inst_i;
      pc_o    <= pc_i;
      op1_o   <= op1_i;
      op2_o   <= op2_i;
      waddr_o <= waddr_i;
      we_o    <= we_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage as a 2-entry skid buffer; ready_o comes straight from
// a flop so execute back-pressure never reaches decode combinationally.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] NOP_INST   = NOP_INST_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [31:0]           inst_i,
  input  logic [DATA_WIDTH-1:0] inst_addr_i,
  input  logic [DATA_WIDTH-1:0] op1_i,
  input  logic [DATA_WIDTH-1:0] op2_i,
  input  logic [REG_ADDR_W-1:0] reg_waddr_i,
  input  logic                  reg_we_i,
  input  logic                  flush_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [31:0]           inst_o,
  output logic [DATA_WIDTH-1:0] inst_addr_o,
  output logic [DATA_WIDTH-1:0] op1_o,
  output logic [DATA_WIDTH-1:0] op2_o,
  output logic [REG_ADDR_W-1:0] reg_waddr_o,
  output logic                  reg_we_o
);

  stage_state_e state_r, state_nxt;
  logic valid_r, ready_r;
  logic accept, drain;
  logic main_load, skid_load, main_from_skid;

  logic [31:0]           skid_inst, main_inst, main_d_inst;
  logic [DATA_WIDTH-1:0] skid_pc, main_pc, main_d_pc;
  logic [DATA_WIDTH-1:0] skid_op1, main_op1, main_d_op1;
  logic [DATA_WIDTH-1:0] skid_op2, main_op2, main_d_op2;
  logic [REG_ADDR_W-1:0] skid_waddr, main_waddr, main_d_waddr;
  logic                  skid_we, main_we, main_d_we;

  assign accept = valid_i && ready_r;
  assign drain  = valid_r && ready_i;

  // next-state and entry load decisions; flush overrides every transfer
  always_comb begin
    state_nxt      = state_r;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (flush_i) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (accept) begin
            state_nxt = ST_BUSY;
            main_load = 1'b1;
          end else begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_BUSY: begin
          if (accept && !drain) begin
            state_nxt = ST_FULL;
            skid_load = 1'b1;
          end else if (!accept && drain) begin
            state_nxt = ST_EMPTY;
          end else if (accept && drain) begin
            state_nxt = ST_BUSY;
            main_load = 1'b1;
          end else begin
            state_nxt = ST_BUSY;
          end
        end
        ST_FULL: begin
          if (drain) begin
            state_nxt      = ST_BUSY;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end else begin
            state_nxt = ST_FULL;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  // main entry is refilled from skid when draining out of FULL, keeping order
  always_comb begin
    if (main_from_skid) begin
      main_d_inst  = skid_inst;
      main_d_pc    = skid_pc;
      main_d_op1   = skid_op1;
      main_d_op2   = skid_op2;
      main_d_waddr = skid_waddr;
      main_d_we    = skid_we;
    end else begin
      main_d_inst  = inst_i;
      main_d_pc    = inst_addr_i;
      main_d_op1   = op1_i;
      main_d_op2   = op2_i;
      main_d_waddr = reg_waddr_i;
      main_d_we    = reg_we_i;
    end
  end

  // state plus registered handshake flags derived from the next state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_EMPTY;
      valid_r <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_nxt;
      valid_r <= (state_nxt != ST_EMPTY);
      ready_r <= (state_nxt != ST_FULL);
    end
  end

  id_ex_entry #(.DATA_WIDTH(DATA_WIDTH)) u_main (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (main_load),
    .inst_i  (main_d_inst),
    .pc_i    (main_d_pc),
    .op1_i   (main_d_op1),
    .op2_i   (main_d_op2),
    .waddr_i (main_d_waddr),
    .we_i    (main_d_we),
    .inst_o  (main_inst),
    .pc_o    (main_pc),
    .op1_o   (main_op1),
    .op2_o   (main_op2),
    .waddr_o (main_waddr),
    .we_o    (main_we)
  );

  id_ex_entry #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (skid_load),
    .inst_i  (inst_i),
    .pc_i    (inst_addr_i),
    .op1_i   (op1_i),
    .op2_i   (op2_i),
    .waddr_i (reg_waddr_i),
    .we_i    (reg_we_i),
    .inst_o  (skid_inst),
    .pc_o    (skid_pc),
    .op1_o   (skid_op1),
    .op2_o   (skid_op2),
    .waddr_o (skid_waddr),
    .we_o    (skid_we)
  );

  // invalid slots present a clean bubble; x0 is never a write target
  assign ready_o     = ready_r;
  assign valid_o     = valid_r;
  assign inst_o      = valid_r ? main_inst  : NOP_INST;
  assign inst_addr_o = valid_r ? main_pc    : {DATA_WIDTH{1'b0}};
  assign op1_o       = valid_r ? main_op1   : {DATA_WIDTH{1'b0}};
  assign op2_o       = valid_r ? main_op2   : {DATA_WIDTH{1'b0}};
  assign reg_waddr_o = valid_r ? main_waddr : {REG_ADDR_W{1'b0}};
  assign reg_we_o    = valid_r && main_we && (main_waddr != {REG_ADDR_W{1'b0}});

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: single pass, back-pressure, streaming,
// flush, x0 destination and asynchronous reset.
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] inst_i = 32'h0;
  logic [31:0] inst_addr_i = 32'h0;
  logic [31:0] op1_i = 32'h0;
  logic [31:0] op2_i = 32'h0;
  logic [4:0]  reg_waddr_i = 5'd0;
  logic        reg_we_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic [31:0] op1_o;
  logic [31:0] op2_o;
  logic [4:0]  reg_waddr_o;
  logic        reg_we_o;

  int total = 0;
  int bad = 0;

  localparam logic [31:0] NOP = 32'h00000013;

  id_ex_stage #(.DATA_WIDTH(32), .NOP_INST(32'h00000013)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i), .op1_i(op1_i), .op2_i(op2_i),
    .reg_waddr_i(reg_waddr_i), .reg_we_i(reg_we_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .inst_o(inst_o),
    .inst_addr_o(inst_addr_o), .op1_o(op1_o), .op2_o(op2_o),
    .reg_waddr_o(reg_waddr_o), .reg_we_o(reg_we_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic [4:0] wa, input logic we);
    valid_i     = v;
    inst_i      = inst;
    inst_addr_i = pc;
    op1_i       = pc ^ 32'hA5A5_0000;
    op2_i       = inst;
    reg_waddr_i = wa;
    reg_we_i    = we;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, 32'(valid_o), 32'd0);
    chk({tag, "_ready"}, 32'(ready_o), 32'd1);
    chk({tag, "_inst"}, inst_o, NOP);
    chk({tag, "_we"}, 32'(reg_we_o), 32'd0);
    chk({tag, "_waddr"}, 32'(reg_waddr_o), 32'd0);
    chk({tag, "_pc"}, inst_addr_o, 32'd0);
    chk({tag, "_op1"}, op1_o, 32'd0);
    chk({tag, "_op2"}, op2_o, 32'd0);
  endtask

  initial begin
    // reset
    tick();
    tick();
    chk_bubble("rst");
    rst_i = 1'b0;
    tick();
    chk_bubble("post_rst");

    // single pass
    ready_i = 1'b1;
    valid_i = 1'b1; inst_i = 32'h00500093; inst_addr_i = 32'h100;
    op1_i = 32'd0; op2_i = 32'd5; reg_waddr_i = 5'd1; reg_we_i = 1'b1;
    tick();
    chk("sp_valid", 32'(valid_o), 32'd1);
    chk("sp_inst", inst_o, 32'h00500093);
    chk("sp_we", 32'(reg_we_o), 32'd1);
    chk("sp_waddr", 32'(reg_waddr_o), 32'd1);
    chk("sp_op2", op2_o, 32'd5);
    chk("sp_pc", inst_addr_o, 32'h100);
    valid_i = 1'b0;
    tick();
    chk_bubble("sp_drained");

    // back-pressure: A then B fill both entries
    ready_i = 1'b0;
    drive(1'b1, 32'h00A00113, 32'h200, 5'd2, 1'b1);
    tick();
    chk("bp_a_valid", 32'(valid_o), 32'd1);
    chk("bp_a_ready", 32'(ready_o), 32'd1);
    chk("bp_a_inst", inst_o, 32'h00A00113);
    drive(1'b1, 32'h00B00193, 32'h204, 5'd3, 1'b1);
    tick();
    chk("bp_full_ready", 32'(ready_o), 32'd0);
    chk("bp_full_inst", inst_o, 32'h00A00113);
    drive(1'b1, 32'h00C00213, 32'h208, 5'd4, 1'b1);
    tick();
    chk("bp_hold_ready", 32'(ready_o), 32'd0);
    chk("bp_hold_inst", inst_o, 32'h00A00113);
    chk("bp_hold_pc", inst_addr_o, 32'h200);
    chk("bp_hold_op1", op1_o, 32'h200 ^ 32'hA5A5_0000);
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    chk("bp_b_valid", 32'(valid_o), 32'd1);
    chk("bp_b_inst", inst_o, 32'h00B00193);
    chk("bp_b_waddr", 32'(reg_waddr_o), 32'd3);
    chk("bp_b_ready", 32'(ready_o), 32'd1);
    tick();
    chk_bubble("bp_empty");

    // streaming: one in, one out per cycle
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h00100093 + 32'(i << 20), 32'(i * 4), 5'd1, 1'b1);
      tick();
      chk("st_valid", 32'(valid_o), 32'd1);
      chk("st_ready", 32'(ready_o), 32'd1);
      chk("st_pc", inst_addr_o, 32'(i * 4));
      chk("st_inst", inst_o, 32'h00100093 + 32'(i << 20));
    end
    valid_i = 1'b0;
    tick();
    chk_bubble("st_empty");

    // x0 destination never writes
    ready_i = 1'b0;
    drive(1'b1, 32'h00000013, 32'h300, 5'd0, 1'b1);
    tick();
    chk("x0_valid", 32'(valid_o), 32'd1);
    chk("x0_we", 32'(reg_we_o), 32'd0);
    chk("x0_pc", inst_addr_o, 32'h300);
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    chk_bubble("x0_empty");

    // flush while FULL with a valid input
    ready_i = 1'b0;
    drive(1'b1, 32'h00A00113, 32'h400, 5'd2, 1'b1);
    tick();
    drive(1'b1, 32'h00B00193, 32'h404, 5'd3, 1'b1);
    tick();
    chk("fl_full_ready", 32'(ready_o), 32'd0);
    flush_i = 1'b1;
    drive(1'b1, 32'h00D00293, 32'h408, 5'd5, 1'b1);
    tick();
    chk_bubble("fl_full");
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    chk_bubble("fl_full_after");

    // flush while BUSY: accepted-looking input must be discarded
    drive(1'b1, 32'h00E00313, 32'h500, 5'd6, 1'b1);
    ready_i = 1'b0;
    tick();
    chk("fb_busy_valid", 32'(valid_o), 32'd1);
    flush_i = 1'b1;
    drive(1'b1, 32'h00F00393, 32'h504, 5'd7, 1'b1);
    tick();
    chk_bubble("fb_flush");
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    chk_bubble("fb_after");

    // asynchronous reset mid-cycle while FULL
    ready_i = 1'b0;
    drive(1'b1, 32'h00A00113, 32'h600, 5'd2, 1'b1);
    tick();
    drive(1'b1, 32'h00B00193, 32'h604, 5'd3, 1'b1);
    tick();
    chk("ar_full_ready", 32'(ready_o), 32'd0);
    chk("ar_full_valid", 32'(valid_o), 32'd1);
    valid_i = 1'b0;
    #1 rst_i = 1'b1;
    #1;
    chk_bubble("ar_async");
    tick();
    rst_i = 1'b0;
    ready_i = 1'b1;
    tick();
    chk_bubble("ar_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand and address width.
REQ-002 Parameter NOP_INST, default 32'h00000013 (addi x0,x0,0), instruction driven when no valid instruction is held.
REQ-003 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 valid_i  input  1  decode presents a valid instruction this cycle.
REQ-006 ready_o  output  1  stage can accept; driven directly from a flop.
REQ-007 inst_i / inst_addr_i  input  32 / DATA_WIDTH  instruction word and its PC.
REQ-008 op1_i / op2_i  input  DATA_WIDTH  resolved operands (op2 = sign-extended immediate for I-type).
REQ-009 reg_waddr_i / reg_we_i  input  5 / 1  destination register and write intent.
REQ-010 flush_i  input  1  discard everything held (branch/jump taken).
REQ-011 valid_o / ready_i  output / input  1 / 1  handshake toward execute.
REQ-012 inst_o, inst_addr_o, op1_o, op2_o, reg_waddr_o, reg_we_o  outputs mirroring REQ-007..009 widths, toward execute.

Function
REQ-013 Transfer in occurs when valid_i && ready_o; transfer out when valid_o && ready_i.
REQ-014 Block is a 2-entry skid buffer: main register (drives outputs) and skid register.
REQ-015 States: EMPTY (no entry), BUSY (main full, skid empty), FULL (both full).
REQ-016 EMPTY: accept -> BUSY, data into main; next cycle valid_o=1 (latency 1 cycle).
REQ-017 BUSY: accept and not drain -> FULL, data into skid; drain and not accept -> EMPTY; accept and drain simultaneously -> stays BUSY, new data into main.
REQ-018 FULL: drain -> BUSY, skid moves to main; no accept possible.
REQ-019 ready_o = 1 in EMPTY and BUSY, 0 in FULL; registered, no combinational path from ready_i.
REQ-020 valid_o = 1 in BUSY and FULL.
REQ-021 Outputs hold stable while valid_o && !ready_i.
REQ-022 When valid_o = 0: inst_o = NOP_INST, reg_we_o = 0, reg_waddr_o = 0, op1_o = op2_o = 0, inst_addr_o = 0.
REQ-023 reg_we_o is additionally forced 0 when reg_waddr_o = 0 (x0 never written).
REQ-024 flush_i has priority over all transfers: next state EMPTY, both entries invalidated, the same-cycle input discarded even if valid_i && ready_o.
REQ-025 Data registers of invalidated entries need not clear; only validity matters, outputs masked per REQ-022.
REQ-026 No ordering reversal: skid entry always exits after main entry.

Reset
REQ-027 rst_i asserted at any time forces state EMPTY immediately, without waiting for clk_i.
REQ-028 During and after reset: ready_o = 1, valid_o = 0, outputs per REQ-022.
REQ-029 Reset mid-transfer discards all held instructions; no partial entry survives.

Structure
REQ-030 NOP_INST, register-address width 5 and state encoding (EMPTY/BUSY/FULL) live in the shared defines file alongside the existing instruction opcode constants.
REQ-031 One sub-module is natural: id_ex_entry, a DATA_WIDTH-parameterised register bundle (inst, pc, op1, op2, waddr, we) with load enable, instantiated twice.
REQ-032 No arithmetic in this block; it feeds the execute units unchanged.

Verification
REQ-033 Single pass: reset, valid_i=1 inst=32'h00500093 op1=0 op2=5 waddr=1, ready_i=1 -> next cycle valid_o=1, inst_o=32'h00500093, reg_we_o=1, reg_waddr_o=1.
REQ-034 Back-pressure: ready_i=0, send A then B -> FULL, ready_o=0 at cycle 3; raise ready_i -> A then B out on consecutive cycles, ready_o=1 after A drains.
REQ-035 Streaming: valid_i=ready_i=1 for 10 cycles with inst_addr 0,4,...,36 -> 10 outputs in order, state stays BUSY, ready_o never drops.
REQ-036 Flush in FULL with valid_i=1: next cycle valid_o=0, inst_o=32'h00000013, ready_o=1, the flushed-cycle input never appears.
REQ-037 x0 destination: reg_waddr_i=0 reg_we_i=1 -> reg_we_o=0 while valid_o=1.
REQ-038 Async reset asserted mid-cycle while FULL -> valid_o=0, ready_o=1 before next clk_i edge.
